// File: rtl/wb_ser_scheduler_pkg.sv
// wb_ser_scheduler_pkg
//   Shared types and constants for the Wishbone serializer scheduler:
//   FSM state encoding, default write address and the k+byte word layout
//   (three 9-bit slots in bits [26:0] of a 32-bit word).
package wb_ser_scheduler_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned SLOT_W    = 9;
  localparam int unsigned NUM_SLOTS = 3;
  localparam int unsigned PAYLOAD_W = SLOT_W * NUM_SLOTS;

  localparam logic [31:0] ADR_WRITE_DEFAULT = 32'h0000_0000;

  // Explicit encodings keep the values identical to the legacy constants.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/wb_ser_scheduler_rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin picker. The search starts at ptr_i and wraps
//   from NUM_REQ-1 back to 0; the first set bit of valid_i wins.
//   Ports:
//     valid_i     - pending request vector
//     ptr_i       - highest-priority index for this search
//     grant_o     - one-hot grant (all zero when nothing is pending)
//     grant_idx_o - binary index of the granted requester
//     any_valid_o - at least one request pending
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDW     = 2
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDW-1:0]     ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDW-1:0]     grant_idx_o,
  output logic               any_valid_o
);

  always_comb begin
    int unsigned idx;
    idx         = 0;
    grant_o     = '0;
    grant_idx_o = '0;
    any_valid_o = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(ptr_i) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any_valid_o && valid_i[idx[IDW-1:0]]) begin
        any_valid_o              = 1'b1;
        grant_idx_o              = idx[IDW-1:0];
        grant_o[idx[IDW-1:0]]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_ser_scheduler.sv
// wb_ser_scheduler
//   Wishbone master sharing one wb_serializer slave between NUM_REQ word
//   producers. A round-robin grant captures one 32-bit word, issues a single
//   write to ADR_WRITE and holds the cycle until ACK_I (or ERR_I / watchdog
//   timeout), then idles for GAP_CYC cycles so the slave can re-arm.
//   Ports:
//     clk_i, rst_ni          - clock, async active-low reset
//     enable_i               - allow new grants
//     req_valid_i/data_i     - per-requester word and valid (slice i = 32 bits)
//     req_ready_o            - one-hot accept pulse
//     done_o, err_o, id_o    - completion pulses and requester index
//     busy_o                 - FSM not idle
//     CYC_O/STB_O/WE_O/ADR_O/DAT_O, ACK_I/ERR_I - Wishbone master side
module wb_ser_scheduler
  import wb_ser_scheduler_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter logic [31:0] ADR_WRITE   = ADR_WRITE_DEFAULT,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned GAP_CYC     = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         enable_i,
  input  logic [NUM_REQ-1:0]           req_valid_i,
  input  logic [NUM_REQ*WORD_W-1:0]    req_data_i,
  output logic [NUM_REQ-1:0]           req_ready_o,
  output logic                         done_o,
  output logic                         err_o,
  output logic [$clog2(NUM_REQ)-1:0]   id_o,
  output logic                         busy_o,
  output logic                         CYC_O,
  output logic                         STB_O,
  output logic                         WE_O,
  output logic [31:0]                  ADR_O,
  output logic [31:0]                  DAT_O,
  input  logic                         ACK_I,
  input  logic                         ERR_I
);

  localparam int unsigned IDW   = $clog2(NUM_REQ);
  localparam int unsigned T_MAX = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
  localparam int unsigned TW    = $clog2(T_MAX + 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CYC - 1);

  state_t             state_q;
  logic [IDW-1:0]     ptr_q;
  logic [TW-1:0]      timer_q;
  logic               cyc_q;
  logic [31:0]        dat_q;
  logic [IDW-1:0]     id_q;
  logic               done_q;
  logic               err_q;

  logic [NUM_REQ-1:0] grant;
  logic [IDW-1:0]     grant_idx;
  logic               any_valid;
  logic               take;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_arb (
    .valid_i     (req_valid_i),
    .ptr_i       (ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .any_valid_o (any_valid)
  );

  assign take = (state_q == ST_IDLE) && enable_i && any_valid;

  // The ready pulse is combinational from IDLE; rst_ni gates it so it stays
  // low while the block is held in reset.
  assign req_ready_o = (take && rst_ni) ? grant : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      timer_q <= '0;
      cyc_q   <= 1'b0;
      dat_q   <= '0;
      id_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (take) begin
            dat_q   <= req_data_i[WORD_W*grant_idx +: WORD_W];
            id_q    <= grant_idx;
            ptr_q   <= (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            timer_q <= '0;
            cyc_q   <= 1'b1;
            state_q <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          // ERR_I and the watchdog take priority over a simultaneous ACK_I.
          if (ERR_I || (timer_q == TO_LAST)) begin
            cyc_q   <= 1'b0;
            err_q   <= 1'b1;
            timer_q <= '0;
            state_q <= ST_GAP;
          end else if (ACK_I) begin
            cyc_q   <= 1'b0;
            done_q  <= 1'b1;
            timer_q <= '0;
            state_q <= ST_GAP;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        ST_GAP: begin
          if (timer_q == GAP_LAST) begin
            timer_q <= '0;
            state_q <= ST_IDLE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: begin
          cyc_q   <= 1'b0;
          timer_q <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign CYC_O  = cyc_q;
  assign STB_O  = cyc_q;
  assign WE_O   = cyc_q;
  assign ADR_O  = ADR_WRITE;
  assign DAT_O  = dat_q;
  assign id_o   = id_q;
  assign done_o = done_q;
  assign err_o  = err_q;
  assign busy_o = (state_q != ST_IDLE);

endmodule

// File: tb/tb_wb_ser_scheduler.sv
// tb_wb_ser_scheduler
//   Directed bench for wb_ser_scheduler (NUM_REQ=4, TIMEOUT_CYC=64,
//   GAP_CYC=1). Inputs change and outputs are sampled on the falling edge.
module tb_wb_ser_scheduler;

  localparam logic [31:0] ADR = 32'h0000_0040;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         enable;
  logic [3:0]   valid;
  logic [127:0] data;
  logic [3:0]   ready;
  logic         done, err, busy;
  logic [1:0]   id;
  logic         cyc, stb, we;
  logic [31:0]  adr, dat;
  logic         ack, werr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_ser_scheduler #(
    .NUM_REQ     (4),
    .ADR_WRITE   (ADR),
    .TIMEOUT_CYC (64),
    .GAP_CYC     (1)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .enable_i    (enable),
    .req_valid_i (valid),
    .req_data_i  (data),
    .req_ready_o (ready),
    .done_o      (done),
    .err_o       (err),
    .id_o        (id),
    .busy_o      (busy),
    .CYC_O       (cyc),
    .STB_O       (stb),
    .WE_O        (we),
    .ADR_O       (adr),
    .DAT_O       (dat),
    .ACK_I       (ack),
    .ERR_I       (werr)
  );

  task automatic test_reset;
    rst_n = 1'b0; enable = 1'b0; valid = '0; data = '0; ack = 1'b0; werr = 1'b0;
    repeat (3) @(negedge clk);
    total++; if ({cyc, stb, we} !== 3'b000) begin bad++; $display("FAIL reset_ctl: got %b want 000", {cyc, stb, we}); end
    total++; if (dat !== 32'h0) begin bad++; $display("FAIL reset_dat: got %h want 0", dat); end
    total++; if ({ready, done, err, id, busy} !== 9'h0) begin bad++; $display("FAIL reset_misc: got %h want 0", {ready, done, err, id, busy}); end
    total++; if (adr !== ADR) begin bad++; $display("FAIL adr: got %h want %h", adr, ADR); end
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_single;
    int errs;
    enable = 1'b1;
    data[32*2 +: 32] = 32'h0012_3456;
    valid = 4'b0100;
    #1;
    total++; if (ready !== 4'b0100) begin bad++; $display("FAIL single_ready: got %b want 0100", ready); end
    @(negedge clk);
    valid = '0;
    total++; if (ready !== 4'b0000) begin bad++; $display("FAIL single_ready_pulse: got %b want 0000", ready); end
    total++; if ({cyc, stb, we, busy} !== 4'b1111) begin bad++; $display("FAIL single_ctl: got %b want 1111", {cyc, stb, we, busy}); end
    total++; if (dat !== 32'h0012_3456) begin bad++; $display("FAIL single_dat: got %h want 00123456", dat); end
    errs = 0;
    for (int k = 1; k < 40; k++) begin
      @(negedge clk);
      if (cyc !== 1'b1 || dat !== 32'h0012_3456 || done !== 1'b0 || err !== 1'b0) errs++;
    end
    total++; if (errs != 0) begin bad++; $display("FAIL single_hold: got %0d bad cycles want 0", errs); end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    total++; if ({done, err, id} !== 4'b1010) begin bad++; $display("FAIL single_done: got done/err/id=%b want 1010", {done, err, id}); end
    total++; if (cyc !== 1'b0) begin bad++; $display("FAIL single_drop: got cyc=%b want 0", cyc); end
    @(negedge clk);
    total++; if ({done, cyc, busy} !== 3'b000) begin bad++; $display("FAIL single_gap: got done/cyc/busy=%b want 000", {done, cyc, busy}); end
  endtask

  task automatic test_round_robin;
    logic [1:0] g;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) data[32*i +: 32] = 32'h0000_0A00 + i;
    valid = 4'b1111; enable = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int n = 0; n < 5; n++) begin
      g = 2'(n % 4);
      total++; if (ready !== (4'b0001 << g)) begin bad++; $display("FAIL rr_grant%0d: got %b want %b", n, ready, 4'b0001 << g); end
      @(negedge clk);
      total++; if (stb !== 1'b1 || dat !== (32'h0000_0A00 + 32'(g))) begin bad++; $display("FAIL rr_dat%0d: got stb=%b dat=%h want 1 %h", n, stb, dat, 32'h0000_0A00 + 32'(g)); end
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      if (n == 4) valid = '0;
      total++; if ({done, id, cyc, ready} !== {1'b1, g, 1'b0, 4'b0000}) begin bad++; $display("FAIL rr_done%0d: got done=%b id=%0d cyc=%b ready=%b want 1 %0d 0 0000", n, done, id, cyc, ready, g); end
      @(negedge clk);
    end
  endtask

  task automatic test_timeout;
    int cnt;
    logic seen_done;
    data[32*1 +: 32] = 32'h0111_1111;
    valid = 4'b0010;
    #1;
    total++; if (ready !== 4'b0010) begin bad++; $display("FAIL to_grant: got %b want 0010", ready); end
    @(negedge clk);
    valid = '0;
    cnt = 0; seen_done = 1'b0;
    while (stb === 1'b1 && cnt < 100) begin
      cnt++;
      if (done === 1'b1) seen_done = 1'b1;
      @(negedge clk);
    end
    total++; if (cnt != 64) begin bad++; $display("FAIL to_len: got %0d stb cycles want 64", cnt); end
    total++; if ({err, done, seen_done, id} !== 5'b10001) begin bad++; $display("FAIL to_err: got err/done/seen/id=%b want 10001", {err, done, seen_done, id}); end
    @(negedge clk);
    data[32*3 +: 32] = 32'h0333_3333;
    valid = 4'b1000;
    #1;
    total++; if (ready !== 4'b1000) begin bad++; $display("FAIL to_next_grant: got %b want 1000", ready); end
    @(negedge clk);
    valid = '0;
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    total++; if ({done, err, id} !== 4'b1011) begin bad++; $display("FAIL to_next_done: got %b want 1011", {done, err, id}); end
    @(negedge clk);
  endtask

  task automatic test_err_ack;
    valid = 4'b0001;
    #1;
    total++; if (ready !== 4'b0001) begin bad++; $display("FAIL ea_grant: got %b want 0001", ready); end
    @(negedge clk);
    valid = '0;
    ack = 1'b1; werr = 1'b1;
    @(negedge clk);
    ack = 1'b0; werr = 1'b0;
    total++; if ({err, done, cyc} !== 3'b100) begin bad++; $display("FAIL ea_prio: got err/done/cyc=%b want 100", {err, done, cyc}); end
    @(negedge clk);
  endtask

  task automatic test_enable;
    int errs;
    enable = 1'b0;
    valid = 4'b1111;
    errs = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (ready !== 4'b0000 || cyc !== 1'b0) errs++;
    end
    total++; if (errs != 0) begin bad++; $display("FAIL en_off: got %0d bad cycles want 0", errs); end
    enable = 1'b1;
    #1;
    total++; if (ready !== 4'b0010) begin bad++; $display("FAIL en_regrant: got %b want 0010", ready); end
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    total++; if (stb !== 1'b1) begin bad++; $display("FAIL en_inflight: got stb=%b want 1", stb); end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    total++; if ({done, id} !== 3'b101) begin bad++; $display("FAIL en_done: got done/id=%b want 101", {done, id}); end
    errs = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (ready !== 4'b0000 || cyc !== 1'b0 || busy !== 1'b0) errs++;
    end
    total++; if (errs != 0) begin bad++; $display("FAIL en_stay_idle: got %0d bad cycles want 0", errs); end
  endtask

  task automatic test_reset_mid;
    data[32*2 +: 32] = 32'h0222_2222;
    enable = 1'b1;
    #1;
    total++; if (ready !== 4'b0100) begin bad++; $display("FAIL rm_grant: got %b want 0100", ready); end
    @(negedge clk);
    valid = '0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if ({cyc, stb, we, busy} !== 4'b0000) begin bad++; $display("FAIL rm_ctl: got %b want 0000", {cyc, stb, we, busy}); end
    total++; if ({dat, done, err} !== 34'h0) begin bad++; $display("FAIL rm_state: got dat=%h done=%b err=%b want 0", dat, done, err); end
    @(negedge clk);
    rst_n = 1'b1;
    valid = 4'b1111;
    #1;
    total++; if (ready !== 4'b0001) begin bad++; $display("FAIL rm_ptr: got %b want 0001", ready); end
    @(negedge clk);
    valid = '0;
    total++; if ({done, err} !== 2'b00) begin bad++; $display("FAIL rm_no_pulse: got %b want 00", {done, err}); end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_timeout;
    test_err_ack;
    test_enable;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

endmodule
